gpr_wr_arbiter: RTL and testbench

- Shares the single write port of the general-purpose register file (9 x 8-bit registers, 4-bit address) between NUM_REQ writeback sources, e.g. ALU result, memory load and immediate move.
- Arbitrates with a round-robin scheme and registers the winning write into a one-cycle output stage that drives the register-file write port directly.
- Reports per-register pending writes for hazard checks, and flags illegal destination addresses.

---
 rtl/gpr_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_gpr_wr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter
// Round-robin arbiter that shares the single register-file write port among
// NUM_REQ writeback sources, followed by a one-cycle registered write stage.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester valid / one-hot combinational grant
//   req_addr          4 bits per requester, requester i at [4i+3:4i]
//   req_data          8 bits per requester, requester i at [8i+7:8i]
//   hold              suppresses all grants and freezes the RR pointer
//   gpr_w_enable/addr/data  registered register-file write port
//   pend_mask         one-hot of the register currently being written
//   err_addr/err_src  sticky out-of-range flag and first offending requester
//   err_clr           clears err_addr/err_src (a coincident new error wins)
module gpr_wr_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [4*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  hold,
  output logic                  gpr_w_enable,
  output logic [3:0]            gpr_w_addr,
  output logic [7:0]            gpr_w_data,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  err_addr,
  output logic [2:0]            err_src,
  input  logic                  err_clr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             w_en_q, w_en_d;
  logic [3:0]       w_addr_q, w_addr_d;
  logic [7:0]       w_data_q, w_data_d;
  logic             err_q, err_d;
  logic [2:0]       err_src_q, err_src_d;

  logic             found;
  logic [PTR_W-1:0] win_idx;
  logic [3:0]       win_addr;
  logic [7:0]       win_data;
  logic             accept;
  logic             in_range;

  // Returns {found, index} of the first valid requester at or after ptr,
  // wrapping modulo NUM_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [PTR_W-1:0]   p);
    logic [PTR_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(p) + k) % 32'(NUM_REQ);
      if (!res[PTR_W] && v[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    {found, win_idx} = rr_pick(req_valid, ptr_q);
    accept   = found && !hold;

    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr = req_addr[4*i +: 4];
        win_data = req_data[8*i +: 8];
      end
    end
    in_range = (int'(win_addr) < NUM_REGS);

    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    w_en_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    err_d     = err_q;
    err_src_d = err_src_q;

    if (accept) begin
      ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      if (in_range) begin
        w_en_d   = 1'b1;
        w_addr_d = win_addr;
        w_data_d = win_data;
      end
    end

    // A new error in the same cycle as err_clr overrides the clear, and it
    // captures its source because the old flag is being discarded.
    if (accept && !in_range) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_src_d = 3'(win_idx);
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_src_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      err_q     <= 1'b0;
      err_src_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_mask[r] = w_en_q && (w_addr_q == 4'(r));
    end
  end

  assign gpr_w_enable = w_en_q;
  assign gpr_w_addr   = w_addr_q;
  assign gpr_w_data   = w_data_q;
  assign err_addr     = err_q;
  assign err_src      = err_src_q;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed testbench for gpr_wr_arbiter (NUM_REQ=3, NUM_REGS=9).
// Inputs change one time unit after the rising edge; outputs are sampled
// there as well, away from the active edge.
module tb_gpr_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        gpr_w_enable;
  logic [3:0]  gpr_w_addr;
  logic [7:0]  gpr_w_data;
  logic [8:0]  pend_mask;
  logic        err_addr;
  logic [2:0]  err_src;
  logic        err_clr;

  int n_vec = 0;
  int n_bad = 0;

  gpr_wr_arbiter #(.NUM_REQ(3), .NUM_REGS(9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .hold(hold),
    .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr),
    .gpr_w_data(gpr_w_data), .pend_mask(pend_mask),
    .err_addr(err_addr), .err_src(err_src), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // A requester that is not accepted must keep valid asserted.
  for (genvar i = 0; i < 3; i++) begin : g_hs
    assert property (@(posedge clk) disable iff (!rst)
                     (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
    req_addr[4*i +: 4] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", gpr_w_enable); end
    n_vec++; if (gpr_w_addr !== 4'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", gpr_w_addr); end
    n_vec++; if (gpr_w_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", gpr_w_data); end
    n_vec++; if (pend_mask !== 9'h000) begin n_bad++; $display("FAIL reset_pend got %h want 000", pend_mask); end
    n_vec++; if ({err_addr, err_src} !== 4'b0000) begin n_bad++; $display("FAIL reset_err got %b/%0d want 0/0", err_addr, err_src); end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 4'd3, 8'hA5);
    req_valid = 3'b001;
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    n_vec++; if (gpr_w_enable !== 1'b1) begin n_bad++; $display("FAIL single_en got %b want 1", gpr_w_enable); end
    n_vec++; if (gpr_w_addr !== 4'd3) begin n_bad++; $display("FAIL single_addr got %h want 3", gpr_w_addr); end
    n_vec++; if (gpr_w_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", gpr_w_data); end
    n_vec++; if (pend_mask !== 9'h008) begin n_bad++; $display("FAIL single_pend got %h want 008", pend_mask); end
    tick();
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL single_en_drop got %b want 0", gpr_w_enable); end
    n_vec++; if (pend_mask !== 9'h000) begin n_bad++; $display("FAIL single_pend_drop got %h want 000", pend_mask); end
    n_vec++; if (gpr_w_addr !== 4'd3) begin n_bad++; $display("FAIL single_addr_hold got %h want 3", gpr_w_addr); end
  endtask

  // All three valid from pointer 0: grants 0,1,2,0,1,2; then the two
  // still-pending requesters finish (0, then 1) so none drops unaccepted.
  task automatic test_back_to_back();
    logic [2:0] vmask;
    logic [3:0] exp_a [3];
    logic [7:0] exp_d [3];
    logic [8:0] exp_p [3];
    int g;
    exp_a[0] = 4'd1; exp_d[0] = 8'h10; exp_p[0] = 9'h002;
    exp_a[1] = 4'd2; exp_d[1] = 8'h21; exp_p[1] = 9'h004;
    exp_a[2] = 4'd8; exp_d[2] = 8'h32; exp_p[2] = 9'h100;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, exp_a[i], exp_d[i]);
    vmask = 3'b111;
    for (int c = 0; c < 8; c++) begin
      g = c % 3;
      req_valid = vmask;
      #1;
      n_vec++; if (req_ready !== (3'b001 << g)) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want %b", c, req_ready, 3'b001 << g); end
      tick();
      if (c >= 5) vmask[g] = 1'b0;
      req_valid = vmask;
      n_vec++; if (gpr_w_enable !== 1'b1) begin n_bad++; $display("FAIL b2b_en[%0d] got %b want 1", c, gpr_w_enable); end
      n_vec++; if ({gpr_w_addr, gpr_w_data} !== {exp_a[g], exp_d[g]}) begin n_bad++; $display("FAIL b2b_write[%0d] got %h/%h want %h/%h", c, gpr_w_addr, gpr_w_data, exp_a[g], exp_d[g]); end
      n_vec++; if (pend_mask !== exp_p[g]) begin n_bad++; $display("FAIL b2b_pend[%0d] got %h want %h", c, pend_mask, exp_p[g]); end
    end
    tick();
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL b2b_en_end got %b want 0", gpr_w_enable); end
  endtask

  // Entering with pointer 2.
  task automatic test_err_addr();
    set_req(1, 4'd9, 8'h55);
    req_valid = 3'b010;
    #1;
    n_vec++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL err1_ready got %b want 010", req_ready); end
    tick();
    req_valid = 3'b000;
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL err1_en got %b want 0", gpr_w_enable); end
    n_vec++; if ({err_addr, err_src} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL err1_flag got %b/%0d want 1/1", err_addr, err_src); end
    set_req(2, 4'd12, 8'h66);
    req_valid = 3'b100;
    #1;
    n_vec++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL err2_ready got %b want 100", req_ready); end
    tick();
    req_valid = 3'b000;
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL err2_en got %b want 0", gpr_w_enable); end
    n_vec++; if ({err_addr, err_src} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL err2_sticky got %b/%0d want 1/1", err_addr, err_src); end
    n_vec++; if (pend_mask !== 9'h000) begin n_bad++; $display("FAIL err2_pend got %h want 000", pend_mask); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++; if ({err_addr, err_src} !== 4'b0000) begin n_bad++; $display("FAIL err_clr got %b/%0d want 0/0", err_addr, err_src); end
  endtask

  // Entering with pointer 0.
  task automatic test_hold();
    set_req(0, 4'd4, 8'hC0);
    set_req(2, 4'd6, 8'hC2);
    hold = 1'b1;
    req_valid = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL hold_ready[%0d] got %b want 000", c, req_ready); end
      tick();
      n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL hold_en[%0d] got %b want 0", c, gpr_w_enable); end
    end
    hold = 1'b0;
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL hold_rel0 got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    n_vec++; if ({gpr_w_enable, gpr_w_addr, gpr_w_data} !== {1'b1, 4'd4, 8'hC0}) begin n_bad++; $display("FAIL hold_w0 got %b/%h/%h want 1/4/c0", gpr_w_enable, gpr_w_addr, gpr_w_data); end
    #1;
    n_vec++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL hold_rel2 got %b want 100", req_ready); end
    tick();
    req_valid = 3'b000;
    n_vec++; if ({gpr_w_enable, gpr_w_addr, gpr_w_data} !== {1'b1, 4'd6, 8'hC2}) begin n_bad++; $display("FAIL hold_w2 got %b/%h/%h want 1/6/c2", gpr_w_enable, gpr_w_addr, gpr_w_data); end
    tick();
  endtask

  // Entering with pointer 0; a req1 write leaves the pointer at 2 before reset.
  task automatic test_async_reset();
    set_req(1, 4'd5, 8'h77);
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    n_vec++; if ({gpr_w_enable, pend_mask} !== {1'b1, 9'h020}) begin n_bad++; $display("FAIL ar_pre got %b/%h want 1/020", gpr_w_enable, pend_mask); end
    #3;
    rst = 1'b0;
    #1;
    n_vec++; if ({gpr_w_enable, gpr_w_addr, gpr_w_data} !== 13'h0) begin n_bad++; $display("FAIL ar_out got %b/%h/%h want 0/0/00", gpr_w_enable, gpr_w_addr, gpr_w_data); end
    n_vec++; if ({pend_mask, err_addr, err_src} !== 13'h0) begin n_bad++; $display("FAIL ar_pend_err got %h/%b/%0d want 000/0/0", pend_mask, err_addr, err_src); end
    #1;
    rst = 1'b1;
    set_req(1, 4'd1, 8'h91);
    set_req(2, 4'd2, 8'h92);
    req_valid = 3'b110;
    #1;
    n_vec++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL ar_ptr got %b want 010", req_ready); end
    req_valid = 3'b100;
    #1;
    n_vec++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL ar_ready got %b want 100", req_ready); end
    tick();
    req_valid = 3'b000;
    n_vec++; if ({gpr_w_enable, gpr_w_addr, gpr_w_data} !== {1'b1, 4'd2, 8'h92}) begin n_bad++; $display("FAIL ar_write got %b/%h/%h want 1/2/92", gpr_w_enable, gpr_w_addr, gpr_w_data); end
  endtask

  // Entering with pointer 0.
  task automatic test_err_clr_collide();
    set_req(1, 4'd10, 8'h01);
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    n_vec++; if ({err_addr, err_src} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL col_pre got %b/%0d want 1/1", err_addr, err_src); end
    set_req(0, 4'd15, 8'h02);
    req_valid = 3'b001;
    err_clr = 1'b1;
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL col_ready got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    err_clr = 1'b0;
    n_vec++; if ({err_addr, err_src} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL col_err got %b/%0d want 1/0", err_addr, err_src); end
    n_vec++; if (gpr_w_enable !== 1'b0) begin n_bad++; $display("FAIL col_en got %b want 0", gpr_w_enable); end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    hold      = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_err_addr();
    test_hold();
    test_async_reset();
    test_err_clr_collide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
